alu_rs: RTL and testbench
=========================

Name: alu_rs

Overview:
- Reservation station directly upstream of the integer ALU in the out-of-order core.
- Holds up to 8 decoded ALU micro-ops waiting for source operands and snoops the common data bus (CDB) for producer results.
- Issues one ready micro-op per cycle as value_1/value_2/op/des to the ALU.
- Maps the ALU's 3-bit des back to the ROB tag when the result returns.

Parameters:
- ENTRIES, 8, station depth; the slot index is the ALU des, so it is fixed at 2**3.
- XLEN, 32, operand width.
- ROB_W, 4, ROB tag width.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all entries (mispredict).
- in_valid  in  1  dispatch offers a micro-op.
- in_ready  out  1  station has a free slot (combinational from valid bits).
- in_op  in  4  ALU opcode (ADD=0 … GEU=13).
- in_rdy1 / in_rdy2  in  1  operand already available.
- in_val1 / in_val2  in  XLEN  operand value, used when rdy.
- in_tag1 / in_tag2  in  ROB_W  producer tag, used when not rdy.
- in_rob  in  ROB_W  destination ROB tag.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  ROB_W  broadcast tag.
- cdb_value  in  XLEN  broadcast value.
- alu_valid  out  1  registered; an op was issued this cycle.
- alu_op  out  4  registered opcode; 4'hF when idle.
- alu_value_1 / alu_value_2  out  XLEN  registered operands.
- alu_des  out  3  registered slot index.
- res_des  in  3  des returned by the ALU.
- res_rob  out  ROB_W  combinational lookup: issued ROB tag of slot res_des.

Behaviour:
- Per-entry state: busy, op, rdy1, val1, tag1, rdy2, val2, tag2, rob. Plus inflight_rob[8].
- Reset (async, rst_n=0):
  - all busy=0 and inflight_rob=0;
  - alu_valid=0, alu_op=4'hF, alu_value_1/2=0, alu_des=0.
- Insert (in_valid && in_ready):
  - writes the lowest-index non-busy slot and sets it busy.
  - If cdb_valid and cdb_tag equals a not-ready in_tagN in the same cycle, that operand is stored ready with cdb_value.
- Wakeup: every busy entry with rdyN=0 and tagN==cdb_tag while cdb_valid captures cdb_value and sets rdyN=1. Both operands may wake on one broadcast.
- Issue selection:
  - Candidates are busy entries with rdy1 && rdy2, taken from registered state.
  - An entry woken this cycle is eligible next cycle; there is no bypass.
  - Priority goes to the lowest index.
- Issue effect, at the posedge:
  - alu_* take the entry's fields and alu_des = slot;
  - inflight_rob[slot] <= rob;
  - the slot's busy clears.
  - If nothing issues: alu_valid=0, alu_op=4'hF (ALU default yields 0), value outputs hold.
- Latency:
  - operands ready in state at cycle k → alu_* valid after posedge k+1;
  - the ALU result appears at the negedge of the following cycle.
- inflight_rob[slot] is rewritten only at that slot's next issue. This is at least 2 cycles later, so res_rob is stable for the ALU result window.
- Simultaneous insert and issue:
  - the insert picks from free slots before this cycle's issue;
  - a full station does not accept even if it issues in that cycle;
  - the freed slot is available the next cycle.
- Full: in_ready=0 and in_valid is ignored. Empty: alu_valid=0 continuously.
- flush:
  - clears all busy and alu_valid, and sets alu_op=4'hF;
  - an insert in the same cycle is dropped;
  - inflight_rob is untouched.
- Opcodes are passed through unchecked. An illegal op issues as-is.

Decomposition:
- Shared core package:
  - ALU opcode localparams (ADD…GEU, IDLE_OP=4'hF);
  - XLEN and ROB_W;
  - rs_entry_t struct.
- Sub-module alu_rs_pick: an 8-bit lowest-set-bit priority encoder returning index and found flag. It is instantiated twice, once for free-slot select and once for ready select.

Test Plan:
- Basic ready issue:
  - Stimulus: reset, then insert ADD, val1=5, val2=7, both rdy, rob=3.
  - Required: next cycle alu_valid=1, op=0, values 5/7, des=0; with res_des=0, res_rob=3.
- CDB wakeup:
  - Stimulus: insert SUB with tag1=9 not ready, val2=1; two cycles later, cdb_valid with tag 9, value 10.
  - Required: issue exactly 2 cycles after the broadcast with values 10/1. No issue before.
- Same-cycle capture:
  - Stimulus: insert with tag2=4 while cdb tag 4, value 0xFFFF_FFFF.
  - Required: issues the next cycle with alu_value_2=0xFFFF_FFFF.
- Fill and order:
  - Stimulus: insert 8 non-ready ops.
  - Required: in_ready=0 and a ninth insert is ignored. Waking all with one tag issues des 0,1,…,7 on consecutive cycles.
- Full plus issue:
  - Stimulus: full station with slot 2 ready, and in_valid held.
  - Required: no insert that cycle; the insert lands in slot 2 the next cycle.
- Reset and flush mid-operation:
  - Stimulus: assert flush with 3 busy entries.
  - Required: next cycle alu_valid=0, alu_op=4'hF, in_ready=1. Asserting rst_n=0 asynchronously mid-cycle immediately forces the reset values.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station: widths, opcodes,
// per-slot entry layout and the CDB operand-capture helper.
package alu_rs_pkg;

  localparam int RS_ENTRIES = 8;
  localparam int RS_IDX_W   = 3;
  localparam int RS_XLEN    = 32;
  localparam int RS_ROB_W   = 4;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9,
    OP_EQ   = 4'd10,
    OP_NE   = 4'd11,
    OP_GE   = 4'd12,
    OP_GEU  = 4'd13,
    OP_IDLE = 4'hF
  } alu_op_e;

  typedef struct packed {
    logic                busy;
    logic [3:0]          op;
    logic                rdy1;
    logic [RS_XLEN-1:0]  val1;
    logic [RS_ROB_W-1:0] tag1;
    logic                rdy2;
    logic [RS_XLEN-1:0]  val2;
    logic [RS_ROB_W-1:0] tag2;
    logic [RS_ROB_W-1:0] rob;
  } rs_entry_t;

  // Both operands may be satisfied by the same broadcast.
  function automatic rs_entry_t rs_wake(input rs_entry_t           e,
                                        input logic                bc_valid,
                                        input logic [RS_ROB_W-1:0] bc_tag,
                                        input logic [RS_XLEN-1:0]  bc_value);
    rs_entry_t r;
    r = e;
    if (bc_valid && !e.rdy1 && (e.tag1 == bc_tag)) begin
      r.rdy1 = 1'b1;
      r.val1 = bc_value;
    end
    if (bc_valid && !e.rdy2 && (e.tag2 == bc_tag)) begin
      r.rdy2 = 1'b1;
      r.val2 = bc_value;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_pick.sv
// Lowest-set-bit priority encoder: index of the first asserted request
// and a flag saying whether any request was present.
module alu_rs_pick #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_i[i] && !found_o) begin
        idx_o   = IW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: 8 slots, CDB snoop, one lowest-index issue per
// cycle; the slot index doubles as the ALU des and maps back to the ROB tag.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int ENTRIES = RS_ENTRIES,
  parameter int XLEN    = RS_XLEN,
  parameter int ROB_W   = RS_ROB_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_op,
  input  logic                in_rdy1,
  input  logic                in_rdy2,
  input  logic [XLEN-1:0]     in_val1,
  input  logic [XLEN-1:0]     in_val2,
  input  logic [ROB_W-1:0]    in_tag1,
  input  logic [ROB_W-1:0]    in_tag2,
  input  logic [ROB_W-1:0]    in_rob,
  input  logic                cdb_valid,
  input  logic [ROB_W-1:0]    cdb_tag,
  input  logic [XLEN-1:0]     cdb_value,
  output logic                alu_valid,
  output logic [3:0]          alu_op,
  output logic [XLEN-1:0]     alu_value_1,
  output logic [XLEN-1:0]     alu_value_2,
  output logic [RS_IDX_W-1:0] alu_des,
  input  logic [RS_IDX_W-1:0] res_des,
  output logic [ROB_W-1:0]    res_rob
);

  rs_entry_t            entry_q [ENTRIES];
  rs_entry_t            entry_d [ENTRIES];
  logic [ROB_W-1:0]     infl_q  [ENTRIES];
  logic [ROB_W-1:0]     infl_d  [ENTRIES];
  rs_entry_t            new_entry;

  logic [ENTRIES-1:0]   free_vec;
  logic [ENTRIES-1:0]   ready_vec;
  logic [RS_IDX_W-1:0]  free_idx;
  logic [RS_IDX_W-1:0]  iss_idx;
  logic                 free_found;
  logic                 iss_found;
  logic                 do_ins;
  logic                 do_iss;

  logic                 alu_valid_q, alu_valid_d;
  logic [3:0]           alu_op_q,    alu_op_d;
  logic [XLEN-1:0]      alu_v1_q,    alu_v1_d;
  logic [XLEN-1:0]      alu_v2_q,    alu_v2_d;
  logic [RS_IDX_W-1:0]  alu_des_q,   alu_des_d;

  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      free_vec[i]  = ~entry_q[i].busy;
      ready_vec[i] = entry_q[i].busy & entry_q[i].rdy1 & entry_q[i].rdy2;
    end
  end

  alu_rs_pick #(.N(ENTRIES), .IW(RS_IDX_W)) u_pick_free (
    .req_i   (free_vec),
    .idx_o   (free_idx),
    .found_o (free_found)
  );

  alu_rs_pick #(.N(ENTRIES), .IW(RS_IDX_W)) u_pick_ready (
    .req_i   (ready_vec),
    .idx_o   (iss_idx),
    .found_o (iss_found)
  );

  // Free slots are judged before this cycle's issue, so a full station
  // refuses dispatch even while it is emptying a slot.
  assign in_ready = free_found;
  assign do_ins   = in_valid && free_found && !flush;
  assign do_iss   = iss_found && !flush;

  always_comb begin
    new_entry      = '0;
    new_entry.busy = 1'b1;
    new_entry.op   = in_op;
    new_entry.rdy1 = in_rdy1;
    new_entry.val1 = in_val1;
    new_entry.tag1 = in_tag1;
    new_entry.rdy2 = in_rdy2;
    new_entry.val2 = in_val2;
    new_entry.tag2 = in_tag2;
    new_entry.rob  = in_rob;
    new_entry      = rs_wake(new_entry, cdb_valid, cdb_tag, cdb_value);
  end

  always_comb begin
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      entry_d[i] = entry_q[i].busy ? rs_wake(entry_q[i], cdb_valid, cdb_tag, cdb_value)
                                   : entry_q[i];
      infl_d[i]  = infl_q[i];
    end
    alu_valid_d = 1'b0;
    alu_op_d    = OP_IDLE;
    alu_v1_d    = alu_v1_q;
    alu_v2_d    = alu_v2_q;
    alu_des_d   = alu_des_q;

    if (flush) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        entry_d[i].busy = 1'b0;
      end
    end else begin
      // Issue reads the registered entry, so a same-cycle wakeup never bypasses.
      if (do_iss) begin
        alu_valid_d              = 1'b1;
        alu_op_d                 = entry_q[iss_idx].op;
        alu_v1_d                 = entry_q[iss_idx].val1;
        alu_v2_d                 = entry_q[iss_idx].val2;
        alu_des_d                = iss_idx;
        infl_d[iss_idx]          = entry_q[iss_idx].rob;
        entry_d[iss_idx].busy    = 1'b0;
      end
      if (do_ins) begin
        entry_d[free_idx] = new_entry;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        entry_q[i] <= '0;
        infl_q[i]  <= '0;
      end
      alu_valid_q <= 1'b0;
      alu_op_q    <= OP_IDLE;
      alu_v1_q    <= '0;
      alu_v2_q    <= '0;
      alu_des_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        entry_q[i] <= entry_d[i];
        infl_q[i]  <= infl_d[i];
      end
      alu_valid_q <= alu_valid_d;
      alu_op_q    <= alu_op_d;
      alu_v1_q    <= alu_v1_d;
      alu_v2_q    <= alu_v2_d;
      alu_des_q   <= alu_des_d;
    end
  end

  assign alu_valid   = alu_valid_q;
  assign alu_op      = alu_op_q;
  assign alu_value_1 = alu_v1_q;
  assign alu_value_2 = alu_v2_q;
  assign alu_des     = alu_des_q;
  assign res_rob     = infl_q[res_des];

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus random traffic,
// compared against a slot-array behavioural model of the station.
module tb_alu_rs;

  logic        clk, rst_n, flush;
  logic        in_valid, in_ready;
  logic [3:0]  in_op;
  logic        in_rdy1, in_rdy2;
  logic [31:0] in_val1, in_val2;
  logic [3:0]  in_tag1, in_tag2, in_rob;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        alu_valid;
  logic [3:0]  alu_op;
  logic [31:0] alu_value_1, alu_value_2;
  logic [2:0]  alu_des, res_des;
  logic [3:0]  res_rob;

  alu_rs dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rdy1(in_rdy1), .in_rdy2(in_rdy2), .in_val1(in_val1), .in_val2(in_val2),
    .in_tag1(in_tag1), .in_tag2(in_tag2), .in_rob(in_rob),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .alu_valid(alu_valid), .alu_op(alu_op), .alu_value_1(alu_value_1),
    .alu_value_2(alu_value_2), .alu_des(alu_des),
    .res_des(res_des), .res_rob(res_rob)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model: one record per slot plus the expected ALU outputs.
  bit          m_busy [8];
  logic [3:0]  m_op   [8];
  bit          m_r1   [8];
  bit          m_r2   [8];
  logic [31:0] m_v1   [8];
  logic [31:0] m_v2   [8];
  logic [3:0]  m_t1   [8];
  logic [3:0]  m_t2   [8];
  logic [3:0]  m_rob  [8];
  logic [3:0]  m_infl [8];
  logic        m_avalid;
  logic [3:0]  m_aop;
  logic [31:0] m_av1, m_av2;
  logic [2:0]  m_ades;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_busy[i] = 0;
      m_infl[i] = '0;
    end
    m_avalid = 1'b0;
    m_aop    = 4'hF;
    m_av1    = '0;
    m_av2    = '0;
    m_ades   = '0;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    cdb_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic drive(input logic [3:0] op, input logic r1, input logic [31:0] v1,
                       input logic [3:0] t1, input logic r2, input logic [31:0] v2,
                       input logic [3:0] t2, input logic [3:0] rob);
    in_valid = 1'b1;
    in_op    = op;
    in_rdy1  = r1;
    in_val1  = v1;
    in_tag1  = t1;
    in_rdy2  = r2;
    in_val2  = v2;
    in_tag2  = t2;
    in_rob   = rob;
  endtask

  task automatic bcast(input logic v, input logic [3:0] t, input logic [31:0] val);
    cdb_valid = v;
    cdb_tag   = t;
    cdb_value = val;
  endtask

  // One clock: check in_ready, advance model across the edge, check outputs.
  task automatic step();
    int nbusy, free_i, iss_i;
    nbusy = 0; free_i = -1; iss_i = -1;
    for (int i = 0; i < 8; i++) begin
      if (m_busy[i]) nbusy++;
      else if (free_i < 0) free_i = i;
      if (m_busy[i] && m_r1[i] && m_r2[i] && iss_i < 0) iss_i = i;
    end
    chk("in_ready", 64'(in_ready), 64'(nbusy < 8));
    @(posedge clk);
    if (flush) begin
      for (int i = 0; i < 8; i++) m_busy[i] = 0;
      m_avalid = 1'b0;
      m_aop    = 4'hF;
    end else begin
      if (iss_i >= 0) begin
        m_avalid      = 1'b1;
        m_aop         = m_op[iss_i];
        m_av1         = m_v1[iss_i];
        m_av2         = m_v2[iss_i];
        m_ades        = 3'(iss_i);
        m_infl[iss_i] = m_rob[iss_i];
        m_busy[iss_i] = 0;
      end else begin
        m_avalid = 1'b0;
        m_aop    = 4'hF;
      end
      if (cdb_valid) begin
        for (int i = 0; i < 8; i++) begin
          if (m_busy[i] && !m_r1[i] && m_t1[i] == cdb_tag) begin m_r1[i] = 1; m_v1[i] = cdb_value; end
          if (m_busy[i] && !m_r2[i] && m_t2[i] == cdb_tag) begin m_r2[i] = 1; m_v2[i] = cdb_value; end
        end
      end
      if (in_valid && nbusy < 8) begin
        m_busy[free_i] = 1;
        m_op[free_i]   = in_op;
        m_r1[free_i]   = in_rdy1;
        m_v1[free_i]   = in_val1;
        m_t1[free_i]   = in_tag1;
        m_r2[free_i]   = in_rdy2;
        m_v2[free_i]   = in_val2;
        m_t2[free_i]   = in_tag2;
        m_rob[free_i]  = in_rob;
        if (cdb_valid && !in_rdy1 && in_tag1 == cdb_tag) begin m_r1[free_i] = 1; m_v1[free_i] = cdb_value; end
        if (cdb_valid && !in_rdy2 && in_tag2 == cdb_tag) begin m_r2[free_i] = 1; m_v2[free_i] = cdb_value; end
      end
    end
    #1;
    chk("alu_valid", 64'(alu_valid), 64'(m_avalid));
    chk("alu_op", 64'(alu_op), 64'(m_aop));
    chk("alu_value_1", 64'(alu_value_1), 64'(m_av1));
    chk("alu_value_2", 64'(alu_value_2), 64'(m_av2));
    chk("alu_des", 64'(alu_des), 64'(m_ades));
    res_des = 3'($urandom_range(0, 7));
    #1;
    chk("res_rob", 64'(res_rob), 64'(m_infl[res_des]));
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    drive(4'd0, 1'b0, '0, '0, 1'b0, '0, '0, '0);
    in_valid = 1'b0;
    bcast(1'b0, '0, '0);
    res_des = '0;
    model_reset();

    #7;
    chk("reset_valid", 64'(alu_valid), 64'd0);
    chk("reset_op", 64'(alu_op), 64'hF);
    chk("reset_v1", 64'(alu_value_1), 64'd0);
    chk("reset_v2", 64'(alu_value_2), 64'd0);
    chk("reset_des", 64'(alu_des), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_res_rob", 64'(res_rob), 64'd0);
    #5 rst_n = 1'b1;

    // Basic ready issue
    drive(4'd0, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 4'd3);
    step();
    idle();
    step();
    chk("basic_valid", 64'(alu_valid), 64'd1);
    chk("basic_op", 64'(alu_op), 64'd0);
    chk("basic_v1", 64'(alu_value_1), 64'd5);
    chk("basic_v2", 64'(alu_value_2), 64'd7);
    chk("basic_des", 64'(alu_des), 64'd0);
    res_des = 3'd0;
    #1;
    chk("basic_res_rob", 64'(res_rob), 64'd3);

    // CDB wakeup: issue exactly two cycles after the broadcast
    drive(4'd1, 1'b0, 32'd0, 4'd9, 1'b1, 32'd1, 4'd0, 4'd5);
    step();
    idle();
    step();
    chk("wake_early1", 64'(alu_valid), 64'd0);
    bcast(1'b1, 4'd9, 32'd10);
    step();
    chk("wake_early2", 64'(alu_valid), 64'd0);
    bcast(1'b0, 4'd0, 32'd0);
    step();
    chk("wake_valid", 64'(alu_valid), 64'd1);
    chk("wake_op", 64'(alu_op), 64'd1);
    chk("wake_v1", 64'(alu_value_1), 64'd10);
    chk("wake_v2", 64'(alu_value_2), 64'd1);

    // Same-cycle capture on insert
    drive(4'd2, 1'b1, 32'd2, 4'd0, 1'b0, 32'd0, 4'd4, 4'd6);
    bcast(1'b1, 4'd4, 32'hFFFF_FFFF);
    step();
    idle();
    step();
    chk("capture_valid", 64'(alu_valid), 64'd1);
    chk("capture_v2", 64'(alu_value_2), 64'hFFFF_FFFF);

    // Fill and in-order drain
    for (int i = 0; i < 8; i++) begin
      drive(4'(i), 1'b0, 32'd0, 4'd5, 1'b1, 32'(i), 4'd0, 4'(i));
      step();
    end
    idle();
    chk("full_in_ready", 64'(in_ready), 64'd0);
    drive(4'd3, 1'b1, 32'd99, 4'd0, 1'b1, 32'd98, 4'd0, 4'hF);
    step();
    idle();
    bcast(1'b1, 4'd5, 32'd100);
    step();
    bcast(1'b0, 4'd0, 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("drain_valid", 64'(alu_valid), 64'd1);
      chk("drain_des", 64'(alu_des), 64'(i));
    end

    // Full station with slot 2 ready and dispatch held
    for (int i = 0; i < 8; i++) begin
      drive(4'd0, 1'b0, 32'd0, 4'(i + 1), 1'b1, 32'd0, 4'd0, 4'(i));
      step();
    end
    idle();
    bcast(1'b1, 4'd3, 32'd33);
    step();
    bcast(1'b0, 4'd0, 32'd0);
    drive(4'd8, 1'b1, 32'd77, 4'd0, 1'b1, 32'd88, 4'd0, 4'hA);
    chk("fullissue_in_ready", 64'(in_ready), 64'd0);
    step();
    chk("fullissue_des", 64'(alu_des), 64'd2);
    chk("fullissue_v1", 64'(alu_value_1), 64'd33);
    chk("freed_in_ready", 64'(in_ready), 64'd1);
    step();
    idle();
    step();
    chk("landed_valid", 64'(alu_valid), 64'd1);
    chk("landed_des", 64'(alu_des), 64'd2);
    chk("landed_v1", 64'(alu_value_1), 64'd77);
    res_des = 3'd2;
    #1;
    chk("landed_res_rob", 64'(res_rob), 64'hA);

    // Flush with three busy entries, one of them about to issue
    flush = 1'b1;
    step();
    idle();
    drive(4'd4, 1'b0, 32'd0, 4'd12, 1'b1, 32'd1, 4'd0, 4'd1);
    step();
    step();
    drive(4'd5, 1'b1, 32'd4, 4'd0, 1'b1, 32'd6, 4'd0, 4'd2);
    step();
    flush = 1'b1;
    step();
    chk("flush_valid", 64'(alu_valid), 64'd0);
    chk("flush_op", 64'(alu_op), 64'hF);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    idle();
    step();
    chk("flush_after_valid", 64'(alu_valid), 64'd0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_op     = 4'($urandom_range(0, 15));
      in_rdy1   = ($urandom_range(0, 2) == 0);
      in_rdy2   = ($urandom_range(0, 2) == 0);
      in_val1   = $urandom;
      in_val2   = $urandom;
      in_tag1   = 4'($urandom_range(0, 3));
      in_tag2   = 4'($urandom_range(0, 3));
      in_rob    = 4'($urandom_range(0, 15));
      cdb_valid = 1'($urandom_range(0, 1));
      cdb_tag   = 4'($urandom_range(0, 3));
      cdb_value = $urandom;
      flush     = ($urandom_range(0, 39) == 0);
      step();
    end

    // Asynchronous reset mid-cycle
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("areset_valid", 64'(alu_valid), 64'd0);
    chk("areset_op", 64'(alu_op), 64'hF);
    chk("areset_v1", 64'(alu_value_1), 64'd0);
    chk("areset_v2", 64'(alu_value_2), 64'd0);
    chk("areset_des", 64'(alu_des), 64'd0);
    chk("areset_in_ready", 64'(in_ready), 64'd1);
    chk("areset_res_rob", 64'(res_rob), 64'd0);
    model_reset();
    #1 rst_n = 1'b1;

    for (int n = 0; n < 40; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_op     = 4'($urandom_range(0, 15));
      in_rdy1   = 1'($urandom_range(0, 1));
      in_rdy2   = 1'($urandom_range(0, 1));
      in_val1   = $urandom;
      in_val2   = $urandom;
      in_tag1   = 4'($urandom_range(0, 15));
      in_tag2   = 4'($urandom_range(0, 15));
      in_rob    = 4'($urandom_range(0, 15));
      cdb_valid = 1'($urandom_range(0, 1));
      cdb_tag   = 4'($urandom_range(0, 15));
      cdb_value = $urandom;
      flush     = 1'b0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
